rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port (RegWrite/A3/WD) between two writeback sources:
//  - port 0: the in-order pipeline WB stage.
//  - port 1: the long-latency multiply/divide unit (MDU).
//  Sits between the WB stage/MDU and the register file. Drives a registered write that is
//  stable at posedge for the file's write phase. Starvation-bounded fixed priority (WB wins).
// PARAMETERS
//  DATA_W       32  register data width
//  ADDR_W       5   register address width (32 registers, x0 hard-wired zero)
//  STARVE_LIMIT 4   consecutive cycles MDU may be denied before it is force-granted
// PORTS
//  CLK        in  1       clock; all state updates on posedge
//  RST_N      in  1       asynchronous active-low reset
//  wb_valid   in  1       WB write request
//  wb_addr    in  ADDR_W  WB destination register
//  wb_data    in  DATA_W  WB write data
//  wb_ready   out 1       WB request accepted this cycle (valid&ready = transfer)
//  md_valid   in  1       MDU write request; held stable with addr/data until md_ready
//  md_addr    in  ADDR_W  MDU destination register
//  md_data    in  DATA_W  MDU write data
//  md_ready   out 1       MDU request accepted this cycle
//  RegWrite   out 1       register-file write enable (registered)
//  A3         out ADDR_W  register-file write address (registered)
//  WD         out DATA_W  register-file write data (registered)
//  rd_a1      in  ADDR_W  register-file read address 1 (bypass compare)
//  rd_a2      in  ADDR_W  register-file read address 2
//  rf_rd1     in  DATA_W  RD1 from register file
//  rf_rd2     in  DATA_W  RD2 from register file
//  fwd_rd1    out DATA_W  read data 1 after optional bypass
//  fwd_rd2    out DATA_W  read data 2 after optional bypass
//  starved    out 1       high while the FSM is in FORCE_MD
// BEHAVIOUR
//  - Reset (async, RST_N=0):
//    - RegWrite=0, A3=0, WD=0; starve_cnt=0; state=WB_PRI.
//    - wb_ready=0 and md_ready=0 while RST_N=0.
//    - Mid-operation reset drops any unaccepted request; the requester must re-present it.
//  - FSM states:
//    - WB_PRI: grant WB if wb_valid, else MDU if md_valid.
//      - Cycle with md_valid & !md_ready: starve_cnt+1.
//      - MDU grant: starve_cnt clears.
//      - starve_cnt reaching STARVE_LIMIT: next state FORCE_MD.
//    - FORCE_MD: grant MDU unconditionally (md_valid is always high here); wb_ready=0.
//      - Next state WB_PRI; starve_cnt=0.
//  - Readys are combinational from state and valids:
//    - wb_ready = state==WB_PRI.
//    - md_ready = (state==FORCE_MD) | (state==WB_PRI & !wb_valid).
//  - Latency: a request accepted at posedge N drives RegWrite/A3/WD during cycle N+1; the file
//    commits it at posedge N+1. Throughput: one write per cycle. With no grant, RegWrite=0 and
//    A3/WD hold their values.
//  - x0: an accepted request with addr==0 completes the handshake but leaves RegWrite=0.
//  - Same addr on both ports in one cycle: only the granted write issues. The loser waits, so
//    ordering is the caller's concern. The pipeline stalls on MDU-destination hazards upstream.
//  - starve_cnt saturates at STARVE_LIMIT; it is ceil(log2(STARVE_LIMIT+1)) bits wide.
// CONFIGURATION
//  RF_WRITE_BYPASS_EN defined:
//    - fwd_rdN = WD when RegWrite & A3==rd_aN & rd_aN!=0; otherwise rf_rdN.
//    - Covers the cycle where the file's read precedes the registered write.
//  RF_WRITE_BYPASS_EN undefined: fwd_rdN = rf_rdN (pure wire); ports remain present.
// STRUCTURE
//  Package rf_arb_pkg: DATA_W/ADDR_W localparams and the state enum {WB_PRI, FORCE_MD}.
//  Sub-module rf_bypass_mux: one compare+mux per read port, instantiated twice; only
//  instantiated under RF_WRITE_BYPASS_EN.
// TESTING
//  1. WB only: wb_valid, addr=5, data=0xDEAD_BEEF -> wb_ready=1; next cycle RegWrite=1, A3=5, WD=0xDEADBEEF.
//  2. Both valid, STARVE_LIMIT=4, WB continuous:
//     - WB wins 4 cycles; cycle 5 md_ready=1, wb_ready=0, starved=1.
//     - Cycle 6 WB wins again.
//  3. x0 write: md_valid, addr=0, data=7, wb idle -> md_ready=1; next cycle RegWrite=0.
//  4. Reset mid-run: RST_N low while starved=1 -> RegWrite=0, starved=0 at once.
//     After release, WB is granted first.
//  5. Bypass:
//     - RF_WRITE_BYPASS_EN on, RegWrite=1, A3=9, WD=0x1234, rd_a1=9 -> fwd_rd1=0x1234.
//     - Same with rd_a1=0 -> fwd_rd1=rf_rd1.
//     - Macro off -> fwd_rd1=rf_rd1.
//  6. Back-to-back: WB writes r1..r8 on consecutive cycles -> eight consecutive RegWrite=1
//     cycles, A3=1..8 in order.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter: default widths and
// the arbitration state type.
package rf_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic [0:0] {
    WB_PRI   = 1'b0,
    FORCE_MD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf_bypass_mux.sv
// One read-port bypass: returns the in-flight registered write data when it
// targets the register being read (never for x0), otherwise the file's data.
module rf_bypass_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic [DATA_W-1:0] q
);

  // Compare the pending write address against the read address and select.
  always_comb begin
    q = rd;
    if (we && (wa == ra) && (ra != '0))
      q = wd;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between the WB stage
// (port 0, fixed priority) and the MDU (port 1, force-granted after
// STARVE_LIMIT consecutive denied cycles). The write is registered.
// Optional read bypass of the registered write: define RF_WRITE_BYPASS_EN.
module rf_write_arbiter #(
  parameter int unsigned DATA_W       = rf_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W       = rf_arb_pkg::ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] rd_a1,
  input  logic [ADDR_W-1:0] rd_a2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] fwd_rd1,
  output logic [DATA_W-1:0] fwd_rd2,
  output logic              starved
);

  import rf_arb_pkg::*;

  localparam int unsigned          CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]     LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             wb_go;
  logic             md_go;

  // Ready generation from state and valids; both readys held low in reset.
  always_comb begin
    wb_ready = RST_N && (state == WB_PRI);
    md_ready = RST_N && ((state == FORCE_MD) || ((state == WB_PRI) && !wb_valid));
    wb_go    = wb_valid && wb_ready;
    md_go    = md_valid && md_ready;
    cnt_inc  = (starve_cnt >= LIMIT_C) ? LIMIT_C : starve_cnt + 1'b1;
  end

  assign starved = (state == FORCE_MD);

  // Arbitration FSM with saturating MDU starvation counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= WB_PRI;
      starve_cnt <= '0;
    end else begin
      case (state)
        WB_PRI: begin
          if (md_go) begin
            starve_cnt <= '0;
          end else if (md_valid) begin
            starve_cnt <= cnt_inc;
            if (cnt_inc == LIMIT_C)
              state <= FORCE_MD;
          end
        end
        FORCE_MD: begin
          state      <= WB_PRI;
          starve_cnt <= '0;
        end
        default: begin
          state      <= WB_PRI;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // Registered write port; x0 completes the handshake but never writes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RegWrite <= 1'b0;
      A3       <= '0;
      WD       <= '0;
    end else if (wb_go) begin
      RegWrite <= (wb_addr != '0);
      A3       <= wb_addr;
      WD       <= wb_data;
    end else if (md_go) begin
      RegWrite <= (md_addr != '0);
      A3       <= md_addr;
      WD       <= md_data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp1 (
    .we (RegWrite),
    .wa (A3),
    .wd (WD),
    .ra (rd_a1),
    .rd (rf_rd1),
    .q  (fwd_rd1)
  );

  rf_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp2 (
    .we (RegWrite),
    .wa (A3),
    .wd (WD),
    .ra (rd_a2),
    .rd (rf_rd2),
    .q  (fwd_rd2)
  );
`else
  assign fwd_rd1 = rf_rd1;
  assign fwd_rd2 = rf_rd2;

  // Read addresses only feed the bypass compare; kept as ports regardless.
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_a1, rd_a2};
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed bench for rf_write_arbiter against a behavioural
// model of the arbitration rules.
module tb_rf_write_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wb_valid, md_valid;
  logic [4:0]  wb_addr, md_addr, rd_a1, rd_a2;
  logic [31:0] wb_data, md_data, rf_rd1, rf_rd2;
  logic        wb_ready, md_ready, RegWrite, starved;
  logic [4:0]  A3;
  logic [31:0] WD, fwd_rd1, fwd_rd2;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive denied MDU cycles and the expected write port.
  int          deny;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          md_taken;

  always #5 CLK = ~CLK;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .RegWrite(RegWrite), .A3(A3), .WD(WD),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2), .starved(starved)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_fwd(input logic [4:0] ra, input logic [31:0] rd);
`ifdef RF_WRITE_BYPASS_EN
    if (m_we && m_a3 == ra && ra != 0) return m_wd;
`endif
    return rd;
  endfunction

  task automatic model_reset();
    deny = 0; m_we = 0; m_a3 = '0; m_wd = '0;
  endtask

  // One clock cycle: inputs already driven (just after a negedge).
  // Checks readys, then advances the model at posedge, then checks outputs.
  task automatic cycle(input string tag);
    bit forced, e_wbr, e_mdr;
    forced = (deny >= LIMIT);
    e_wbr  = !forced;
    e_mdr  = forced || !wb_valid;
    #1;
    check({tag, "_wb_ready"}, {31'b0, wb_ready}, {31'b0, e_wbr});
    check({tag, "_md_ready"}, {31'b0, md_ready}, {31'b0, e_mdr});
    check({tag, "_starved"},  {31'b0, starved},  {31'b0, forced});
    @(posedge CLK);
    md_taken = md_valid && e_mdr;
    if (wb_valid && e_wbr) begin
      m_we = (wb_addr != 0); m_a3 = wb_addr; m_wd = wb_data;
    end else if (md_taken) begin
      m_we = (md_addr != 0); m_a3 = md_addr; m_wd = md_data;
    end else begin
      m_we = 0;
    end
    if (md_taken) deny = 0;
    else if (md_valid && deny < LIMIT) deny++;
    @(negedge CLK);
    rd_a1  = ($urandom_range(1) != 0) ? m_a3 : 5'($urandom);
    rd_a2  = ($urandom_range(1) != 0) ? m_a3 : 5'($urandom);
    rf_rd1 = $urandom;
    rf_rd2 = $urandom;
    #1;
    check({tag, "_RegWrite"}, {31'b0, RegWrite}, {31'b0, m_we});
    check({tag, "_A3"},       {27'b0, A3},       {27'b0, m_a3});
    check({tag, "_WD"},       WD,                m_wd);
    check({tag, "_fwd_rd1"},  fwd_rd1,           exp_fwd(rd_a1, rf_rd1));
    check({tag, "_fwd_rd2"},  fwd_rd2,           exp_fwd(rd_a2, rf_rd2));
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    md_valid = 0; md_addr = '0; md_data = '0;
  endtask

  initial begin
    RST_N = 0;
    idle_inputs();
    rd_a1 = '0; rd_a2 = '0; rf_rd1 = '0; rf_rd2 = '0;
    model_reset();
    #12;
    check("rst_RegWrite", {31'b0, RegWrite}, 32'd0);
    check("rst_A3",       {27'b0, A3},       32'd0);
    check("rst_WD",       WD,                32'd0);
    check("rst_wb_ready", {31'b0, wb_ready}, 32'd0);
    check("rst_md_ready", {31'b0, md_ready}, 32'd0);
    check("rst_starved",  {31'b0, starved},  32'd0);
    @(negedge CLK); RST_N = 1;

    // WB-only single write.
    @(negedge CLK);
    wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    cycle("t1");
    check("t1_A3_abs", {27'b0, A3}, 32'd5);
    check("t1_WD_abs", WD, 32'hDEADBEEF);

    // Starvation: WB continuous, MDU held; forced grant on 5th cycle.
    wb_valid = 1; md_valid = 1; md_addr = 5'd20; md_data = 32'h0000_0D1F;
    for (int i = 0; i < 6; i++) begin
      wb_addr = 5'(10 + i); wb_data = 32'h100 + i;
      #1;
      check($sformatf("t2_c%0d_md_ready", i + 1), {31'b0, md_ready}, {31'b0, (i == 4)});
      check($sformatf("t2_c%0d_wb_ready", i + 1), {31'b0, wb_ready}, {31'b0, (i != 4)});
      cycle($sformatf("t2_c%0d", i + 1));
      if (md_taken) md_valid = 0;
    end

    // x0 write from the MDU completes but does not write.
    idle_inputs();
    md_valid = 1; md_addr = 5'd0; md_data = 32'd7;
    cycle("t3");
    check("t3_RegWrite_abs", {31'b0, RegWrite}, 32'd0);
    md_valid = 0;

    // Reset while starved.
    wb_valid = 1; md_valid = 1; md_addr = 5'd3; md_data = 32'h33;
    for (int i = 0; i < LIMIT; i++) begin
      wb_addr = 5'(i + 1); wb_data = 32'h200 + i;
      cycle("t4_pre");
    end
    check("t4_starved_before", {31'b0, starved}, 32'd1);
    RST_N = 0;
    #1;
    model_reset();
    check("t4_RegWrite", {31'b0, RegWrite}, 32'd0);
    check("t4_starved",  {31'b0, starved},  32'd0);
    check("t4_md_ready", {31'b0, md_ready}, 32'd0);
    @(negedge CLK); RST_N = 1;
    wb_addr = 5'd6; wb_data = 32'h66;
    cycle("t4_post");
    check("t4_post_A3", {27'b0, A3}, 32'd6);
    md_valid = 0;

    // Bypass of the registered write.
    idle_inputs();
    wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h1234;
    cycle("t5");
    wb_valid = 0;
    rd_a1 = 5'd9; rf_rd1 = 32'hAAAA_0000;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("t5_hit", fwd_rd1, 32'h1234);
`else
    check("t5_nobyp", fwd_rd1, 32'hAAAA_0000);
`endif
    rd_a1 = 5'd0;
    #1;
    check("t5_x0", fwd_rd1, 32'hAAAA_0000);

    // Back-to-back WB writes r1..r8.
    for (int i = 1; i <= 8; i++) begin
      wb_valid = 1; wb_addr = 5'(i); wb_data = 32'h8000 + i;
      cycle("t6");
      check($sformatf("t6_A3_%0d", i), {27'b0, A3}, i);
      check($sformatf("t6_we_%0d", i), {31'b0, RegWrite}, 32'd1);
    end
    idle_inputs();

    // Randomized traffic; MDU holds its request until accepted.
    for (int n = 0; n < 400; n++) begin
      wb_valid = ($urandom_range(3) != 0);
      wb_addr  = 5'($urandom);
      wb_data  = $urandom;
      if (!md_valid && $urandom_range(2) == 0) begin
        md_valid = 1; md_addr = 5'($urandom); md_data = $urandom;
      end
      cycle("rnd");
      if (md_taken) md_valid = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
